// File: rtl/reaction_delay_timer.sv
// Reaction-timer hold-off and measurement block: random millisecond delay after
// start_delay rises, then counts the player's reaction time until the trigger press.
module reaction_delay_timer #(
   parameter int LFSR_W      = 7,
   parameter int DELAY_BASE  = 500,
   parameter int DELAY_SHIFT = 4,
   parameter int MAX_REACT   = 9999
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              tick_ms,
   input  logic              start_delay,
   input  logic [LFSR_W-1:0] lfsr_val,
   input  logic              trigger,
   output logic              time_out,
   output logic [13:0]       react_ms,
   output logic              result_valid,
   output logic              false_start,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_WAIT_REACT
   } state_t;

   state_t            state;
   logic              trig_s1;
   logic              trig_s2;
   logic              trig_prev;
   logic              press_q;
   logic              sd_prev;
   logic [11:0]       delay_cnt;
   logic [13:0]       react_cnt;

   logic              sd_rise;
   logic [LFSR_W-1:0] lfsr_eff;
   logic [11:0]       delay_load;

   always_comb begin
      sd_rise    = start_delay & ~sd_prev;
      lfsr_eff   = (lfsr_val == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : lfsr_val;
      delay_load = 12'(DELAY_BASE) + (12'(lfsr_eff) << DELAY_SHIFT);
   end

   // Press is registered once more so the FSM acts three edges after the
   // first low sample of the raw key.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         trig_s1   <= 1'b1;
         trig_s2   <= 1'b1;
         trig_prev <= 1'b1;
         press_q   <= 1'b0;
         sd_prev   <= 1'b0;
      end else begin
         trig_s1   <= trigger;
         trig_s2   <= trig_s1;
         trig_prev <= trig_s2;
         press_q   <= trig_prev & ~trig_s2;
         sd_prev   <= start_delay;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         delay_cnt    <= '0;
         react_cnt    <= '0;
         time_out     <= 1'b0;
         react_ms     <= '0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         // time_out outlives WAIT_REACT; only the FSM dropping start_delay clears it.
         if (!start_delay) begin
            time_out <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (sd_rise) begin
                  delay_cnt <= delay_load;
                  state     <= S_DELAY;
                  busy      <= 1'b1;
               end
            end
            S_DELAY: begin
               if (press_q) begin
                  false_start  <= 1'b1;
                  react_ms     <= '0;
                  result_valid <= 1'b1;
                  state        <= S_IDLE;
                  busy         <= 1'b0;
               end else if (!start_delay) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (tick_ms) begin
                  if (delay_cnt == 12'd1) begin
                     delay_cnt <= '0;
                     react_cnt <= '0;
                     time_out  <= 1'b1;
                     state     <= S_WAIT_REACT;
                  end else begin
                     delay_cnt <= delay_cnt - 12'd1;
                  end
               end
            end
            S_WAIT_REACT: begin
               if (press_q) begin
                  react_ms     <= react_cnt;
                  false_start  <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= S_IDLE;
                  busy         <= 1'b0;
               end else if (tick_ms) begin
                  if (react_cnt >= 14'(MAX_REACT - 1)) begin
                     react_cnt    <= 14'(MAX_REACT);
                     react_ms     <= 14'(MAX_REACT);
                     false_start  <= 1'b0;
                     result_valid <= 1'b1;
                     state        <= S_IDLE;
                     busy         <= 1'b0;
                  end else begin
                     react_cnt <= react_cnt + 14'd1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Directed plus randomized checks of reaction_delay_timer against an arithmetic
// model of the hold-off / reaction outcome.
module tb_reaction_delay_timer;

   localparam int LW = 7;
   localparam int DB = 5;
   localparam int DS = 0;
   localparam int MR = 50;

   logic          CLOCK_50 = 1'b0;
   logic          reset_n;
   logic          tick_ms;
   logic          start_delay;
   logic [LW-1:0] lfsr_val;
   logic          trigger;
   logic          time_out;
   logic [13:0]   react_ms;
   logic          result_valid;
   logic          false_start;
   logic          busy;

   int n_cmp = 0;
   int n_fail = 0;
   int rv_count = 0;
   int exp_pulses = 0;

   reaction_delay_timer #(
      .LFSR_W(LW),
      .DELAY_BASE(DB),
      .DELAY_SHIFT(DS),
      .MAX_REACT(MR)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset_n(reset_n),
      .tick_ms(tick_ms),
      .start_delay(start_delay),
      .lfsr_val(lfsr_val),
      .trigger(trigger),
      .time_out(time_out),
      .react_ms(react_ms),
      .result_valid(result_valid),
      .false_start(false_start),
      .busy(busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) begin
      if (result_valid === 1'b1) rv_count++;
   end

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_tick();
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_delay(input int v);
      return DB + ((v == 0 ? 1 : v) << DS);
   endfunction

   // Press the key, then check the three-edge latency and single-cycle pulse.
   task automatic press_check(input string tag, input int exp_react, input logic exp_fs);
      trigger = 1'b0;
      step(); step(); step();
      check({tag, "_rv_early"}, result_valid, 1'b0);
      step();
      check({tag, "_rv"}, result_valid, 1'b1);
      check({tag, "_react"}, react_ms, exp_react);
      check({tag, "_fs"}, false_start, exp_fs);
      exp_pulses++;
      step();
      check({tag, "_rv_width"}, result_valid, 1'b0);
   endtask

   task automatic cleanup();
      start_delay = 1'b0;
      trigger = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      int v, d, p, nt, exp_react;
      logic fs, sat;

      reset_n = 1'b0;
      tick_ms = 1'b0;
      start_delay = 1'b0;
      lfsr_val = '0;
      trigger = 1'b1;
      step(); step();
      check("rst_time_out", time_out, 1'b0);
      check("rst_react", react_ms, 14'd0);
      check("rst_rv", result_valid, 1'b0);
      check("rst_fs", false_start, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      step();

      // Normal run: D = 8, reaction 42
      lfsr_val = 7'd3;
      start_delay = 1'b1;
      step();
      check("norm_busy", busy, 1'b1);
      repeat (7) do_tick();
      check("norm_to_early", time_out, 1'b0);
      do_tick();
      check("norm_to", time_out, 1'b1);
      repeat (42) do_tick();
      press_check("norm", 42, 1'b0);
      check("norm_busy_end", busy, 1'b0);
      check("norm_to_held", time_out, 1'b1);
      start_delay = 1'b0;
      step();
      check("norm_to_fall", time_out, 1'b0);
      cleanup();

      // False start after 4 ticks
      lfsr_val = 7'd3;
      start_delay = 1'b1;
      step();
      repeat (4) do_tick();
      press_check("fstart", 0, 1'b1);
      check("fstart_to", time_out, 1'b0);
      check("fstart_busy", busy, 1'b0);
      cleanup();

      // lfsr_val 0 treated as 1 -> 6 ticks
      lfsr_val = 7'd0;
      start_delay = 1'b1;
      step();
      repeat (5) do_tick();
      check("lfsr0_to_early", time_out, 1'b0);
      do_tick();
      check("lfsr0_to", time_out, 1'b1);
      press_check("lfsr0", 0, 1'b0);
      cleanup();

      // Press and expiry tick on the same edge
      lfsr_val = 7'd3;
      start_delay = 1'b1;
      step();
      repeat (7) do_tick();
      trigger = 1'b0;
      step(); step(); step();
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      check("simexp_rv", result_valid, 1'b1);
      check("simexp_fs", false_start, 1'b1);
      check("simexp_react", react_ms, 14'd0);
      check("simexp_to", time_out, 1'b0);
      exp_pulses++;
      step();
      cleanup();

      // Press and tick on the same edge with react_cnt = 17
      lfsr_val = 7'd3;
      start_delay = 1'b1;
      step();
      repeat (8 + 17) do_tick();
      trigger = 1'b0;
      step(); step(); step();
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      check("simtick_rv", result_valid, 1'b1);
      check("simtick_react", react_ms, 14'd17);
      exp_pulses++;
      step();
      cleanup();

      // Saturation at MR, later press gives nothing
      lfsr_val = 7'd3;
      start_delay = 1'b1;
      step();
      repeat (8 + MR - 1) do_tick();
      check("sat_no_early", rv_count, exp_pulses);
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      check("sat_rv", result_valid, 1'b1);
      check("sat_react", react_ms, 14'(MR));
      check("sat_fs", false_start, 1'b0);
      check("sat_busy", busy, 1'b0);
      exp_pulses++;
      step();
      trigger = 1'b0;
      repeat (6) step();
      check("sat_no_second", rv_count, exp_pulses);
      cleanup();

      // start_delay dropped mid-DELAY
      lfsr_val = 7'd3;
      start_delay = 1'b1;
      step();
      repeat (3) do_tick();
      start_delay = 1'b0;
      step();
      check("abort_busy", busy, 1'b0);
      repeat (10) do_tick();
      check("abort_to", time_out, 1'b0);
      check("abort_pulses", rv_count, exp_pulses);
      cleanup();

      // Reset mid-DELAY
      lfsr_val = 7'd3;
      start_delay = 1'b1;
      step();
      repeat (2) do_tick();
      reset_n = 1'b0;
      #1;
      check("rstd_busy", busy, 1'b0);
      check("rstd_react", react_ms, 14'd0);
      check("rstd_fs", false_start, 1'b0);
      start_delay = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      // Reset mid-WAIT_REACT
      start_delay = 1'b1;
      step();
      repeat (8 + 5) do_tick();
      check("rstw_pre_to", time_out, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rstw_to", time_out, 1'b0);
      check("rstw_busy", busy, 1'b0);
      check("rstw_rv", result_valid, 1'b0);
      start_delay = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      check("rst_pulses", rv_count, exp_pulses);

      // Randomized runs against the outcome model
      for (int it = 0; it < 10; it++) begin
         v = $urandom_range(0, 20);
         d = model_delay(v);
         p = $urandom_range(0, d + MR + 4);
         if (p < d) begin
            fs = 1'b1; sat = 1'b0; exp_react = 0;
         end else if (p - d < MR) begin
            fs = 1'b0; sat = 1'b0; exp_react = p - d;
         end else begin
            fs = 1'b0; sat = 1'b1; exp_react = MR;
         end
         lfsr_val = LW'(v);
         start_delay = 1'b1;
         step();
         nt = sat ? d + MR : p;
         repeat (nt) do_tick();
         if (sat) begin
            exp_pulses++;
            check("rnd_sat_pulse", rv_count, exp_pulses);
            check("rnd_sat_react", react_ms, exp_react);
            trigger = 1'b0;
            repeat (6) step();
            check("rnd_sat_no_second", rv_count, exp_pulses);
         end else begin
            press_check("rnd", exp_react, fs);
         end
         check("rnd_to", time_out, !fs);
         check("rnd_busy", busy, 1'b0);
         cleanup();
         check("rnd_to_clear", time_out, 1'b0);
      end

      check("pulse_total", rv_count, exp_pulses);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
